// File: rtl/debug_pkg.sv
// Purpose: shared page encodings, reset constants and display helpers for debug_capture.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package debug_pkg;

   // Display pages, in the order the page button steps through them.
   typedef enum logic [1:0] {
      PAGE_WADDR = 2'd0,
      PAGE_WDATA = 2'd1,
      PAGE_RADDR = 2'd2,
      PAGE_WCNT  = 2'd3
   } page_e;

   localparam logic [15:0] RST_WORD = 16'h0000;
   localparam logic [3:0]  RST_DOTS = 4'b0001;
   localparam page_e       RST_PAGE = PAGE_WADDR;
   localparam logic        RST_BIT  = 1'b0;

   // One dot per page: the lit dot tells the operator which page is shown.
   function automatic logic [3:0] page_dots(input page_e p);
      page_dots = 4'b0001 << p;
   endfunction

endpackage

// File: rtl/debounce.sv
// Purpose: 2-flop synchronizer plus counting debouncer for a raw push button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles, then dout/rise update one edge later.
// Backpressure: none; the input is sampled every cycle.
//
// Ports:
//   clk   in  system clock, rising edge
//   reset in  synchronous active-high reset
//   din   in  raw asynchronous button level
//   dout  out accepted (debounced) level
//   rise  out one-cycle pulse when the accepted level goes 0 -> 1
module debounce
   import debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise
);

   // Counter only has to reach DEBOUNCE_CYCLES-1: acceptance happens on the
   // cycle that would otherwise step past it.
   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync0;
   logic          r_sync1;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync0 <= RST_BIT;
         r_sync1 <= RST_BIT;
         r_level <= RST_BIT;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync0 <= din;
         r_sync1 <= r_sync0;
         r_rise  <= 1'b0;
         if (r_sync1 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_sync1;
               r_cnt   <= '0;
               r_rise  <= r_sync1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            // Any sample agreeing with the accepted level is a bounce: restart.
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_level;
   assign rise = r_rise;

endmodule

// File: rtl/debug_capture.sv
// Purpose: captures CPU bus write/read activity and pages it onto a 4-digit hex display.
// Latency: data0/data1 reflect a capture or page change one clock later.
// Backpressure: none; every qualified strobe is captured, the bus is never stalled.
//
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset
//   bus_addr in  [15:0] CPU bus address
//   bus_data in  [15:0] CPU bus write data
//   bus_we   in  write strobe (one-cycle qualifier)
//   bus_re   in  read strobe (one-cycle qualifier)
//   btn      in  raw asynchronous page button, active-high
//   data0    out [15:0] value for the hex display
//   data1    out [3:0]  one-hot dot enables marking the current page
//
// Build option: define DEBUG_CAPTURE_FILTER_EN to capture only addresses with
// (bus_addr & FILT_MASK) == FILT_BASE; otherwise every strobe is captured.
module debug_capture
   import debug_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [15:0] FILT_BASE       = 16'h0000,
   parameter logic [15:0] FILT_MASK       = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bus_addr,
   input  logic [15:0] bus_data,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic        btn,
   output logic [15:0] data0,
   output logic [3:0]  data1
);

   logic [15:0] r_wr_addr;
   logic [15:0] r_wr_data;
   logic [15:0] r_rd_addr;
   logic [15:0] r_wr_cnt;
   page_e       r_page;
   logic [15:0] r_data0;
   logic [3:0]  r_data1;

   logic [15:0] w_wr_addr_nxt;
   logic [15:0] w_wr_data_nxt;
   logic [15:0] w_rd_addr_nxt;
   logic [15:0] w_wr_cnt_nxt;
   page_e       w_page_nxt;
   logic [15:0] w_data0_nxt;
   logic        w_cap_ok;
   logic        w_btn_lvl;
   logic        w_btn_rise;

`ifdef DEBUG_CAPTURE_FILTER_EN
   assign w_cap_ok = ((bus_addr & FILT_MASK) == FILT_BASE);
`else
   assign w_cap_ok = 1'b1;
`endif

   debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (btn),
      .dout  (w_btn_lvl),
      .rise  (w_btn_rise)
   );

   // The display register is loaded from the next-state values so a capture
   // and a page change landing in the same cycle both show up one clock later.
   always_comb begin
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_rd_addr_nxt = r_rd_addr;
      w_wr_cnt_nxt  = r_wr_cnt;
      w_page_nxt    = r_page;
      w_data0_nxt   = RST_WORD;

      if (bus_we && w_cap_ok) begin
         w_wr_addr_nxt = bus_addr;
         w_wr_data_nxt = bus_data;
         w_wr_cnt_nxt  = r_wr_cnt + 16'd1;   // wraps FFFF -> 0000
      end
      if (bus_re && w_cap_ok) begin
         w_rd_addr_nxt = bus_addr;
      end
      // rise only pulses as the accepted level goes high; the level check
      // keeps the page tied to a pressed button.
      if (w_btn_rise && w_btn_lvl) begin
         w_page_nxt = page_e'(r_page + 2'd1);
      end

      case (w_page_nxt)
         PAGE_WADDR: w_data0_nxt = w_wr_addr_nxt;
         PAGE_WDATA: w_data0_nxt = w_wr_data_nxt;
         PAGE_RADDR: w_data0_nxt = w_rd_addr_nxt;
         PAGE_WCNT:  w_data0_nxt = w_wr_cnt_nxt;
         default:    w_data0_nxt = RST_WORD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_addr <= RST_WORD;
         r_wr_data <= RST_WORD;
         r_rd_addr <= RST_WORD;
         r_wr_cnt  <= RST_WORD;
         r_page    <= RST_PAGE;
         r_data0   <= RST_WORD;
         r_data1   <= RST_DOTS;
      end else begin
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_rd_addr <= w_rd_addr_nxt;
         r_wr_cnt  <= w_wr_cnt_nxt;
         r_page    <= w_page_nxt;
         r_data0   <= w_data0_nxt;
         r_data1   <= page_dots(w_page_nxt);
      end
   end

   assign data0 = r_data0;
   assign data1 = r_data1;

endmodule

// File: tb/tb_debug_capture.sv
// Purpose: randomized scoreboard bench for debug_capture against a run-length reference model.
// Latency: expectations are queued by stimulus and compared at the next falling edge.
// Backpressure: n/a (bench).
module tb_debug_capture;

   localparam int DEB = 8;

   logic        clk;
   logic        reset;
   logic [15:0] bus_addr;
   logic [15:0] bus_data;
   logic        bus_we;
   logic        bus_re;
   logic        btn;
   logic [15:0] data0;
   logic [3:0]  data1;

   debug_capture #(
      .DEBOUNCE_CYCLES (DEB),
      .FILT_BASE       (16'hFF00),
      .FILT_MASK       (16'hFF00)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus_addr (bus_addr),
      .bus_data (bus_data),
      .bus_we   (bus_we),
      .bus_re   (bus_re),
      .btn      (btn),
      .data0    (data0),
      .data1    (data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0] m_waddr, m_wdata, m_raddr, m_wcnt;
   int          m_page;
   logic        m_lvl;      // accepted button level
   int          m_run;      // consecutive raw samples disagreeing with m_lvl
   logic        m_btn;      // level the bench is holding on btn

   typedef struct {
      logic [15:0] d0;
      logic [3:0]  d1;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic bit cap_ok(input logic [15:0] a);
`ifdef DEBUG_CAPTURE_FILTER_EN
      return a[15:8] == 8'hFF;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [15:0] exp_d0();
      case (m_page)
         0:       return m_waddr;
         1:       return m_wdata;
         2:       return m_raddr;
         default: return m_wcnt;
      endcase
   endfunction

   task automatic model_clear();
      m_waddr = 16'h0; m_wdata = 16'h0; m_raddr = 16'h0; m_wcnt = 16'h0;
      m_page = 0; m_lvl = 1'b0; m_run = 0;
   endtask

   // Synchronizer delay is a pure shift, so run lengths on the raw input
   // decide acceptance exactly.
   task automatic model_apply(input logic we, input logic re, input logic [15:0] a,
                              input logic [15:0] d, input logic b);
      if (reset) return;
      if (we && cap_ok(a)) begin
         m_waddr = a; m_wdata = d; m_wcnt = m_wcnt + 16'd1;
      end
      if (re && cap_ok(a)) m_raddr = a;
      if (b != m_lvl) begin
         m_run++;
         if (m_run == DEB) begin
            m_lvl = b;
            m_run = 0;
            if (b) m_page = (m_page + 1) % 4;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic step(input logic we, input logic re, input logic [15:0] a,
                       input logic [15:0] d, input logic b);
      bus_we = we; bus_re = re; bus_addr = a; bus_data = d; btn = b;
      model_apply(we, re, a, d, b);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 16'($urandom), 16'($urandom), m_btn);
   endtask

   task automatic expect_now(input string name);
      exp_t e;
      e.d0 = exp_d0();
      e.d1 = 4'b0001 << m_page;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic press(input int hi, input int lo);
      m_btn = 1'b1; idle(hi);
      m_btn = 1'b0; idle(lo);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      step(1'b1, 1'b1, 16'hFF77, 16'h1111, m_btn);   // strobes must be ignored
      expect_now("reset_state");
      step(1'b1, 1'b0, 16'hFF66, 16'h2222, m_btn);
      step(1'b0, 1'b0, 16'h0, 16'h0, m_btn);
      reset = 1'b0;
   endtask

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(1, 0) == 1) a[15:8] = 8'hFF;
      return a;
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (data0 === e.d0 && data1 === e.d1) n_pass++;
            else $display("FAIL %s: got data0=%h data1=%b, expected data0=%h data1=%b",
                          e.name, data0, data1, e.d0, e.d1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int op;
      logic [15:0] a;
      reset = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = 16'h0; bus_data = 16'h0;
      btn = 1'b0; m_btn = 1'b0;
      model_clear();
      @(posedge clk); #1;

      do_reset();
      idle(5);
      expect_now("idle_after_reset");

      // write then one press -> write data page
      step(1'b1, 1'b0, 16'h1234, 16'hBEEF, 1'b0);
      expect_now("write_latency_page0");
      press(12, 12);
      expect_now("press_to_page1");

      // bounce: 5 high, 1 low, 10 high -> exactly one advance
      press(5, 1);
      expect_now("short_pulse_no_advance");
      press(10, 12);
      expect_now("bounce_then_hold_one_advance");
      press(DEB - 1, 12);
      expect_now("pulse_one_short_of_limit");
      press(DEB, 12);
      expect_now("pulse_exactly_limit");

      // simultaneous write and read, then walk all pages
      step(1'b1, 1'b1, 16'h0100, 16'h5A5A, 1'b0);
      expect_now("we_re_same_cycle");
      for (int i = 0; i < 4; i++) begin
         press(12, 12);
         expect_now("page_walk");
      end

      // reset mid-debounce discards the partial count
      press(5, 0);
      m_btn = 1'b1;
      do_reset();
      idle(5);
      m_btn = 1'b0;
      idle(12);
      expect_now("reset_mid_debounce");

      // address filter behaviour (model decides per build)
      step(1'b1, 1'b0, 16'h1000, 16'hAAAA, 1'b0);
      expect_now("filter_write_1000");
      step(1'b1, 1'b0, 16'hFF12, 16'h5555, 1'b0);
      expect_now("filter_write_FF12");
      press(12, 12);
      expect_now("filter_data_page");

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         op = int'($urandom_range(4, 0));
         a = rand_addr();
         case (op)
            0: step(1'b1, 1'b0, a, 16'($urandom), 1'b0);
            1: step(1'b0, 1'b1, a, 16'($urandom), 1'b0);
            2: step(1'b1, 1'b1, a, 16'($urandom), 1'b0);
            3: press(int'($urandom_range(14, 1)), 12);
            default: idle(int'($urandom_range(3, 1)));
         endcase
         expect_now("random");
      end

      // write counter wraps
      do_reset();
      for (int i = 0; i < 3; i++) press(12, 12);
      expect_now("wcnt_page_zero");
      repeat (65535) step(1'b1, 1'b0, 16'hFF55, 16'h0000, 1'b0);
      idle(2);
      expect_now("wcnt_ffff");
      step(1'b1, 1'b0, 16'hFF55, 16'h0000, 1'b0);
      expect_now("wcnt_wrap");

      // drain the scoreboard, bounded
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
